// File: rtl/freq_meter_multichannel.sv
// Multi-channel gated frequency meter: synchronised inputs, BCD edge counters, latched results on valid/ready.
// Define FREQ_METER_CONTINUOUS_EN for back-to-back gates (results overwritten if not accepted).
module freq_meter_multichannel #(
    parameter int CHANNELS    = 2,
    parameter int DIGITS_NUM  = 6,
    parameter int GATE_W      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             clk_in,
    input  logic                             reset_in,
    input  logic [CHANNELS-1:0]              sig_in,
    input  logic [GATE_W-1:0]                gate_len_in,
    output logic [CHANNELS*4*DIGITS_NUM-1:0] digits_out,
    output logic [CHANNELS-1:0]              overflow_out,
    output logic                             valid_out,
    input  logic                             ready_in,
    output logic                             overrun_out,
    output logic                             gate_active_out
);

    localparam int CW = 4 * DIGITS_NUM;
    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {S_START, S_MEASURE, S_LATCH, S_WAIT} state_t;

    state_t                            state_q, state_d;
    logic [GATE_W-1:0]                 gate_q, gate_d;
    logic [SS-1:0][CHANNELS-1:0]       sync_q;
    logic [CHANNELS-1:0]               hist_q;
    logic [CHANNELS-1:0]               edge_w;
    logic [CHANNELS-1:0][CW-1:0]       cnt_q, cnt_d;
    logic [CHANNELS-1:0]               ovf_q, ovf_d;
    logic [CHANNELS*CW-1:0]            digits_q, digits_d;
    logic [CHANNELS-1:0]               ovfo_q, ovfo_d;
    logic                              valid_q, valid_d;
    logic                              overrun_q, overrun_d;
    logic                              accept_w;

    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < DIGITS_NUM; d++) begin
            if (carry) begin
                if (v[4*d +: 4] == 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = v[4*d +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic is_max(input logic [CW-1:0] v);
        logic m;
        m = 1'b1;
        for (int d = 0; d < DIGITS_NUM; d++) begin
            if (v[4*d +: 4] != 4'd9) m = 1'b0;
        end
        return m;
    endfunction

    assign edge_w          = sync_q[SS-1] & ~hist_q;
    assign accept_w        = valid_q & ready_in;
    assign gate_active_out = (state_q == S_MEASURE);
    assign digits_out      = digits_q;
    assign overflow_out    = ovfo_q;
    assign valid_out       = valid_q;
    assign overrun_out     = overrun_q;

    always_comb begin
        state_d   = state_q;
        gate_d    = gate_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        digits_d  = digits_q;
        ovfo_d    = ovfo_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (accept_w) valid_d = 1'b0;
        case (state_q)
            S_START: begin
                gate_d  = (gate_len_in == '0) ? '0 : gate_len_in - GATE_W'(1);
                cnt_d   = '0;
                ovf_d   = '0;
                state_d = S_MEASURE;
            end
            S_MEASURE: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (edge_w[c]) begin
                        if (is_max(cnt_q[c])) ovf_d[c] = 1'b1;
                        else                  cnt_d[c] = bcd_inc(cnt_q[c]);
                    end
                end
                if (gate_q == '0) state_d = S_LATCH;
                else              gate_d  = gate_q - GATE_W'(1);
            end
            S_LATCH: begin
                digits_d = cnt_q;
                ovfo_d   = ovf_q;
                // A new latch overrides a same-cycle acceptance, so valid stays high.
                valid_d  = 1'b1;
                if (valid_q && !ready_in) overrun_d = 1'b1;
`ifdef FREQ_METER_CONTINUOUS_EN
                state_d  = S_START;
`else
                state_d  = S_WAIT;
`endif
            end
            S_WAIT: begin
                if (accept_w) state_d = S_START;
            end
            default: state_d = S_START;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= S_START;
            gate_q    <= '0;
            sync_q    <= '0;
            hist_q    <= '0;
            cnt_q     <= '0;
            ovf_q     <= '0;
            digits_q  <= '0;
            ovfo_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gate_q    <= gate_d;
            sync_q    <= {sync_q[SS-2:0], sig_in};
            hist_q    <= sync_q[SS-1];
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            digits_q  <= digits_d;
            ovfo_q    <= ovfo_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_freq_meter_multichannel.sv
// Directed bench for freq_meter_multichannel: a 6-digit instance and a 2-digit instance share the inputs.
module tb_freq_meter_multichannel;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic [1:0]  sig_in = 2'b00;
    logic [23:0] gate_len = 24'd1000;
    logic [23:0] gate_len2 = 24'd400;
    logic        ready = 1'b1;
    logic        ready2 = 1'b1;

    logic [47:0] digits;
    logic [1:0]  ovf;
    logic        valid, overrun, gact;
    logic [15:0] digits2;
    logic [1:0]  ovf2;
    logic        valid2, overrun2, gact2;

    int n_tests = 0;
    int n_fail  = 0;
    int per [2];
    int ph  [2];
    logic konst [2];

    always #5 clk_in = ~clk_in;

    freq_meter_multichannel #(.CHANNELS(2), .DIGITS_NUM(6), .GATE_W(24), .SYNC_STAGES(2)) u_dut (
        .clk_in(clk_in), .reset_in(reset_in), .sig_in(sig_in), .gate_len_in(gate_len),
        .digits_out(digits), .overflow_out(ovf), .valid_out(valid), .ready_in(ready),
        .overrun_out(overrun), .gate_active_out(gact)
    );

    freq_meter_multichannel #(.CHANNELS(2), .DIGITS_NUM(2), .GATE_W(24), .SYNC_STAGES(2)) u_dut2 (
        .clk_in(clk_in), .reset_in(reset_in), .sig_in(sig_in), .gate_len_in(gate_len2),
        .digits_out(digits2), .overflow_out(ovf2), .valid_out(valid2), .ready_in(ready2),
        .overrun_out(overrun2), .gate_active_out(gact2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: outputs are settled 1 time unit after the edge, then the inputs advance.
    task automatic tick();
        @(posedge clk_in);
        #1;
        for (int c = 0; c < 2; c++) begin
            if (reset_in) begin
                sig_in[c] = 1'b0;
                ph[c]     = 0;
            end else if (per[c] > 0) begin
                sig_in[c] = (ph[c] >= per[c] / 2);
                ph[c]     = (ph[c] + 1) % per[c];
            end else begin
                sig_in[c] = konst[c];
            end
        end
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (valid && n < 4000) begin
            tick();
            n++;
        end
        while (!valid && n < 4000) begin
            tick();
            n++;
        end
        if (!valid) chk({tag, "_timeout"}, 64'(valid), 64'd1);
    endtask

    initial begin
        int n;
        per[0] = 10; per[1] = 2;
        ph[0] = 0;   ph[1] = 0;
        konst[0] = 1'b0; konst[1] = 1'b0;

        #1 reset_in = 1'b1;
        tick();
        tick();
        reset_in = 1'b0;
        chk("rst_digits",  64'(digits),  64'd0);
        chk("rst_ovf",     64'(ovf),     64'd0);
        chk("rst_valid",   64'(valid),   64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_gact",    64'(gact),    64'd0);
        chk("rst_valid2",  64'(valid2),  64'd0);

        // First gates after reset: 1000 cycles (period 10 / period 2) and 400 cycles on the 2-digit unit.
        for (int k = 1; k <= 1003; k++) begin
            tick();
            if (k == 1) begin
                chk("gact_start",  64'(gact),  64'd1);
                chk("gact2_start", 64'(gact2), 64'd1);
            end
            if (k == 401) chk("valid2_early", 64'(valid2), 64'd0);
            if (k == 402) begin
                chk("valid2_lat",  64'(valid2),  64'd1);
                chk("digits2_sat", 64'(digits2), 64'h9940);
                chk("ovf2_sat",    64'(ovf2),    64'd2);
            end
            if (k == 1001) begin
                chk("valid_early", 64'(valid), 64'd0);
                chk("gact_latch",  64'(gact),  64'd0);
            end
            if (k == 1002) begin
                chk("valid_lat",  64'(valid),  64'd1);
                chk("digits_g1",  64'(digits), 64'h000499_000100);
                chk("ovf_g1",     64'(ovf),    64'd0);
            end
            if (k == 1003) chk("valid_pulse", 64'(valid), 64'd0);
        end

        // Sink stalls for 5000 cycles.
        ready = 1'b0;
        for (int k = 1; k <= 5000; k++) begin
            tick();
`ifndef FREQ_METER_CONTINUOUS_EN
            if (k == 2500) chk("hold_mid", 64'(digits), 64'h000500_000100);
`endif
        end
        chk("hold_valid",  64'(valid),  64'd1);
        chk("hold_digits", 64'(digits), 64'h000500_000100);
`ifdef FREQ_METER_CONTINUOUS_EN
        chk("hold_overrun", 64'(overrun), 64'd1);
`else
        chk("hold_overrun", 64'(overrun), 64'd0);
        chk("hold_gact",    64'(gact),    64'd0);
`endif
        ready = 1'b1;
        tick();
`ifndef FREQ_METER_CONTINUOUS_EN
        chk("accept_drop", 64'(valid), 64'd0);
`endif

        // Gate length changed mid-gate: applies to the following gate only.
        wait_valid("chg_sync", n);
        repeat (300) tick();
        gate_len = 24'd500;
        wait_valid("chg_cur", n);
        chk("chg_cur_digits",  64'(digits), 64'h000500_000100);
        wait_valid("chg_next", n);
        chk("chg_next_digits", 64'(digits), 64'h000250_000050);

        // Zero gate length with constant-high inputs.
        gate_len = 24'd0;
        per[0] = 0; per[1] = 0;
        konst[0] = 1'b1; konst[1] = 1'b1;
        repeat (3) wait_valid("g0_flush", n);
        wait_valid("g0", n);
`ifdef FREQ_METER_CONTINUOUS_EN
        chk("g0_spacing", 64'(n), 64'd3);
`else
        chk("g0_spacing", 64'(n), 64'd4);
`endif
        chk("g0_digits", 64'(digits), 64'd0);
        chk("g0_ovf",    64'(ovf),    64'd0);
        tick();
        chk("g0_pulse",  64'(valid),  64'd0);

        // Asynchronous reset in the middle of a gate.
        gate_len = 24'd1000;
        per[0] = 10; per[1] = 2;
        repeat (3) wait_valid("pre_rst", n);
        chk("pre_rst_digits", 64'(digits), 64'h000500_000100);
        repeat (200) tick();
        chk("pre_rst_gact", 64'(gact), 64'd1);
        #3 reset_in = 1'b1;
        sig_in = 2'b00;
        #1;
        chk("arst_digits",  64'(digits),  64'd0);
        chk("arst_valid",   64'(valid),   64'd0);
        chk("arst_gact",    64'(gact),    64'd0);
        chk("arst_ovf",     64'(ovf),     64'd0);
        chk("arst_overrun", 64'(overrun), 64'd0);
        tick();
        tick();
        reset_in = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!valid && n < 3000);
        chk("post_rst_latency", 64'(n),      64'd1002);
        chk("post_rst_digits",  64'(digits), 64'h000499_000100);
        chk("overrun2_none",    64'(overrun2), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
